// File: rtl/program_sequencer.sv
// Instruction-address sequencer: stall, absolute jump, PC-relative branch and a call/return stack.
// Optional PC_TRACE_EN macro adds trace_valid/trace_from reporting of taken non-sequential changes.
module program_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int OFF_W       = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_adr,
  input  logic              call,
  input  logic [ADDR_W-1:0] call_adr,
  input  logic              ret,
  input  logic              branch,
  input  logic [OFF_W-1:0]  branch_off,
  output logic [ADDR_W-1:0] address,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_ovf,
  output logic              stack_unf
`ifdef PC_TRACE_EN
  ,
  output logic              trace_valid,
  output logic [ADDR_W-1:0] trace_from
`endif
);

  // sp counts 0..STACK_DEPTH inclusive, so it needs one more state than the index.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] pc_reg, pc_next, pc_inc, off_ext, stack_top;
  logic [SP_W-1:0]   sp_reg, sp_next, sp_dec;
  logic              empty_reg, full_reg, ovf_reg, unf_reg;
  logic              ovf_next, unf_next;
  logic              push, taken;
  logic [ADDR_W-1:0] stack_reg [STACK_DEPTH];

  assign pc_inc    = pc_reg + ADDR_W'(1);
  assign off_ext   = ADDR_W'($signed(branch_off));
  assign sp_dec    = sp_reg - SP_W'(1);
  assign stack_top = stack_reg[sp_dec[IDX_W-1:0]];

  always_comb begin
    pc_next  = pc_reg;
    sp_next  = sp_reg;
    ovf_next = ovf_reg;
    unf_next = unf_reg;
    push     = 1'b0;
    taken    = 1'b0;
    if (stall) begin
      pc_next = pc_reg;
    end else if (jump) begin
      pc_next = jump_adr;
      taken   = 1'b1;
    end else if (call) begin
      if (!full_reg) begin
        push    = 1'b1;
        sp_next = sp_reg + SP_W'(1);
        pc_next = call_adr;
        taken   = 1'b1;
      end else begin
        pc_next  = pc_inc;
        ovf_next = 1'b1;
      end
    end else if (ret) begin
      if (!empty_reg) begin
        sp_next = sp_dec;
        pc_next = stack_top;
        taken   = 1'b1;
      end else begin
        pc_next  = pc_inc;
        unf_next = 1'b1;
      end
    end else if (branch) begin
      pc_next = pc_reg + off_ext;
      taken   = 1'b1;
    end else begin
      pc_next = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= RESET_VEC;
      sp_reg    <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      sp_reg    <= sp_next;
      empty_reg <= (sp_next == '0);
      full_reg  <= (sp_next == SP_W'(STACK_DEPTH));
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset term.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack_reg[sp_reg[IDX_W-1:0]] <= pc_inc;
    end
  end

  assign address     = pc_reg;
  assign stack_empty = empty_reg;
  assign stack_full  = full_reg;
  assign stack_ovf   = ovf_reg;
  assign stack_unf   = unf_reg;

`ifdef PC_TRACE_EN
  logic              trace_valid_reg;
  logic [ADDR_W-1:0] trace_from_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      trace_valid_reg <= 1'b0;
      trace_from_reg  <= RESET_VEC;
    end else begin
      trace_valid_reg <= taken;
      if (taken) begin
        trace_from_reg <= pc_reg;
      end
    end
  end

  assign trace_valid = trace_valid_reg;
  assign trace_from  = trace_from_reg;
`else
  logic unused_taken;
  assign unused_taken = taken;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer (ADDR_W=8, STACK_DEPTH=4, RESET_VEC=0).
// Trace checks are compiled in when PC_TRACE_EN is defined.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       reset, stall, jump, call, ret, branch;
  logic [7:0] jump_adr, call_adr, branch_off;
  logic [7:0] address;
  logic       stack_empty, stack_full, stack_ovf, stack_unf;
`ifdef PC_TRACE_EN
  logic       trace_valid;
  logic [7:0] trace_from;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  program_sequencer #(
    .ADDR_W(8), .OFF_W(8), .STACK_DEPTH(4), .RESET_VEC(8'h00)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .jump(jump), .jump_adr(jump_adr),
    .call(call), .call_adr(call_adr),
    .ret(ret), .branch(branch), .branch_off(branch_off),
    .address(address),
    .stack_empty(stack_empty), .stack_full(stack_full),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
`ifdef PC_TRACE_EN
    , .trace_valid(trace_valid), .trace_from(trace_from)
`endif
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic clear_ctl();
    stall = 0; jump = 0; call = 0; ret = 0; branch = 0;
  endtask

  // Advance one edge and settle; outputs are sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_ctl();
  endtask

  task automatic do_jump(input logic [7:0] a);
    jump = 1; jump_adr = a; tick();
  endtask

  task automatic do_call(input logic [7:0] a);
    call = 1; call_adr = a; tick();
  endtask

  task automatic do_ret();
    ret = 1; tick();
  endtask

  task automatic do_branch(input logic [7:0] off);
    branch = 1; branch_off = off; tick();
  endtask

  initial begin
    clear_ctl();
    jump_adr = 0; call_adr = 0; branch_off = 0;
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_value("reset_addr", address, 8'h00);
    check_value("reset_empty", stack_empty, 1'b1);
    check_value("reset_full", stack_full, 1'b0);
    check_value("reset_ovf", stack_ovf, 1'b0);
    check_value("reset_unf", stack_unf, 1'b0);
`ifdef PC_TRACE_EN
    check_value("reset_tvalid", trace_valid, 1'b0);
    check_value("reset_tfrom", trace_from, 8'h00);
`endif
    reset = 0;

    // Idle counting and stall
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_value($sformatf("idle_%0d", i), address, i);
    end
    stall = 1; tick();
    check_value("stall_1", address, 8'h05);
    stall = 1; tick();
    check_value("stall_2", address, 8'h05);
    tick();
    check_value("resume", address, 8'h06);

    // Relative branches and wrap-around
    do_jump(8'h10);
    check_value("jump_10", address, 8'h10);
    do_branch(8'hFC);
    check_value("branch_neg4", address, 8'h0C);
    do_jump(8'hFE);
    do_branch(8'h05);
    check_value("branch_wrap", address, 8'h03);
    do_jump(8'hFF);
    tick();
    check_value("inc_wrap", address, 8'h00);
    do_branch(8'hFF);
    check_value("branch_zero_m1", address, 8'hFF);

    // Nested calls
    do_jump(8'h10);
    do_call(8'h40);
    check_value("call_40", address, 8'h40);
    check_value("call_nonempty", stack_empty, 1'b0);
    tick(); tick();
    check_value("at_42", address, 8'h42);
    do_call(8'h80);
    check_value("call_80", address, 8'h80);
    tick();
    do_ret();
    check_value("ret_43", address, 8'h43);
    do_jump(8'h13);
    do_ret();
    check_value("ret_11", address, 8'h11);
    check_value("nest_empty", stack_empty, 1'b1);

    // Fill, overflow, drain, underflow
    do_call(8'hA0); do_call(8'hB0); do_call(8'hC0);
    check_value("fill3_full", stack_full, 1'b0);
    do_call(8'hD0);
    check_value("fill4_addr", address, 8'hD0);
    check_value("fill4_full", stack_full, 1'b1);
    check_value("pre_ovf", stack_ovf, 1'b0);
    do_call(8'hE0);
    check_value("ovf_addr", address, 8'hD1);
    check_value("ovf_flag", stack_ovf, 1'b1);
    do_ret();
    check_value("pop1", address, 8'hC1);
    check_value("pop1_full", stack_full, 1'b0);
    do_ret();
    check_value("pop2", address, 8'hB1);
    do_ret();
    check_value("pop3", address, 8'hA1);
    do_ret();
    check_value("pop4", address, 8'h12);
    check_value("pop4_empty", stack_empty, 1'b1);
    check_value("pre_unf", stack_unf, 1'b0);
    do_ret();
    check_value("unf_addr", address, 8'h13);
    check_value("unf_flag", stack_unf, 1'b1);
    check_value("ovf_sticky", stack_ovf, 1'b1);

    // Pushed return address of all-ones wraps to zero
    do_jump(8'hFF);
    do_call(8'h40);
    do_ret();
    check_value("ret_wrap", address, 8'h00);

    // Priority: jump beats call and branch, no push
    do_jump(8'h20);
    jump = 1; jump_adr = 8'h90; call = 1; call_adr = 8'h55; branch = 1; branch_off = 8'h07;
    tick();
    check_value("prio_addr", address, 8'h90);
    check_value("prio_empty", stack_empty, 1'b1);
    do_ret();
    check_value("prio_nopush", address, 8'h91);

    // Reset with two stacked entries and a call pending
    do_call(8'h30);
    do_call(8'h38);
    check_value("two_deep", stack_empty, 1'b0);
    reset = 1; call = 1; call_adr = 8'h77;
    tick();
    reset = 0;
    check_value("rst2_addr", address, 8'h00);
    check_value("rst2_empty", stack_empty, 1'b1);
    check_value("rst2_ovf", stack_ovf, 1'b0);
    check_value("rst2_unf", stack_unf, 1'b0);

`ifdef PC_TRACE_EN
    do_jump(8'h33);
    do_jump(8'h70);
    check_value("trace_addr", address, 8'h70);
    check_value("trace_valid", trace_valid, 1'b1);
    check_value("trace_from", trace_from, 8'h33);
    tick();
    check_value("trace_idle", trace_valid, 1'b0);
    check_value("trace_hold", trace_from, 8'h33);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
